// File: rtl/mac_seq.sv
// mac_seq: control sequencer that feeds operands and stage enables to the 8-bit MAC/requantise datapath.
// Optional stall counter output is built when MAC_SEQ_STALL_CNT_EN is defined.
module mac_seq #(
   parameter int N_IN  = 784,
   parameter int CNT_W = 10
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        start_i,
   output logic        busy_o,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [7:0]  in_image_i,
   input  logic [7:0]  in_weight_i,
   output logic        mac_en_o,
   output logic        acc_en_o,
   output logic        relu_en_o,
   output logic        qdq_en_o,
   output logic        round_en_o,
   output logic        sat_en_o,
   output logic        mac_clear_o,
   output logic [7:0]  image_data_o,
   output logic [7:0]  weight_data_o,
   input  logic [7:0]  dsp_output_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
`ifdef MAC_SEQ_STALL_CNT_EN
   output logic [15:0] stall_cnt_o,
`endif
   output logic [3:0]  state_o,
   output logic [7:0]  out_data_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_DRAIN0, S_DRAIN1, S_RELU, S_QDQ,
      S_MULW, S_ROUND, S_SAT, S_CAPT, S_OUT
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       pipe_q, pipe_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             relu_q, relu_d;
   logic             qdq_q, qdq_d;
   logic             round_q, round_d;
   logic             sat_q, sat_d;
   logic             clear_q, clear_d;
   logic             out_valid_q, out_valid_d;
   logic [7:0]       out_data_q, out_data_d;
   logic             in_hs;
`ifdef MAC_SEQ_STALL_CNT_EN
   logic [15:0]      stall_q, stall_d;
`endif

   // Both ports use valid/ready: a transfer happens on a clock edge where valid and
   // ready are both high; the producer holds valid and data stable until then.
   assign in_hs = in_valid_i & ready_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      // acc_en is mac_en delayed through the MAC's operand and multiplier registers.
      pipe_d      = {pipe_q[0], in_hs};
`ifdef MAC_SEQ_STALL_CNT_EN
      stall_d     = stall_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_LOAD;
               cnt_d   = '0;
`ifdef MAC_SEQ_STALL_CNT_EN
               stall_d = '0;
`endif
            end
         end
         S_LOAD: begin
            if (in_hs) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = S_DRAIN0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
`ifdef MAC_SEQ_STALL_CNT_EN
            if (!in_valid_i && (stall_q != 16'hFFFF)) begin
               stall_d = stall_q + 16'd1;
            end
`endif
         end
         S_DRAIN0: state_d = S_DRAIN1;
         S_DRAIN1: state_d = S_RELU;
         S_RELU:   state_d = S_QDQ;
         S_QDQ:    state_d = S_MULW;
         S_MULW:   state_d = S_ROUND;
         S_ROUND:  state_d = S_SAT;
         S_SAT:    state_d = S_CAPT;
         S_CAPT: begin
            out_data_d  = dsp_output_i;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (out_ready_i) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Stage strobes are registered from the next state so each is a clean flop output.
      ready_d = (state_d == S_LOAD);
      busy_d  = (state_d != S_IDLE);
      relu_d  = (state_d == S_RELU);
      qdq_d   = (state_d == S_QDQ);
      round_d = (state_d == S_ROUND);
      sat_d   = (state_d == S_SAT);
      clear_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         pipe_q      <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         relu_q      <= 1'b0;
         qdq_q       <= 1'b0;
         round_q     <= 1'b0;
         sat_q       <= 1'b0;
         clear_q     <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
`ifdef MAC_SEQ_STALL_CNT_EN
         stall_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pipe_q      <= pipe_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         relu_q      <= relu_d;
         qdq_q       <= qdq_d;
         round_q     <= round_d;
         sat_q       <= sat_d;
         clear_q     <= clear_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
`ifdef MAC_SEQ_STALL_CNT_EN
         stall_q     <= stall_d;
`endif
      end
   end

   assign busy_o        = busy_q;
   assign in_ready_o    = ready_q;
   assign mac_en_o      = in_hs;
   assign acc_en_o      = pipe_q[1];
   assign relu_en_o     = relu_q;
   assign qdq_en_o      = qdq_q;
   assign round_en_o    = round_q;
   assign sat_en_o      = sat_q;
   assign mac_clear_o   = clear_q;
   assign image_data_o  = in_image_i;
   assign weight_data_o = in_weight_i;
   assign out_valid_o   = out_valid_q;
   assign out_data_o    = out_data_q;
   assign state_o       = state_q;
`ifdef MAC_SEQ_STALL_CNT_EN
   assign stall_cnt_o   = stall_q;
`endif

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: two instances (N_IN=4 and N_IN=1), each driving a cycle-level MAC stub.
// Expected neuron results come from a plain arithmetic model: sat(round(relu(sum)*37 / 2^16)).
module tb_mac_seq;

   logic clk;
   logic rstn;

   logic [1:0]        start, in_valid, out_ready;
   logic [1:0][7:0]   in_image, in_weight;
   logic [1:0]        busy, in_ready, mac_en, acc_en, relu_en, qdq_en, round_en, sat_en, mac_clear, out_valid;
   logic [1:0][7:0]   image_data, weight_data, dsp_out, out_data;
   logic [1:0][3:0]   dbg_state;
`ifdef MAC_SEQ_STALL_CNT_EN
   logic [1:0][15:0]  stall_cnt;
`endif

   int n_chk;
   int n_pass;
   logic [8:0] exp_q[$];
   logic [7:0] img_v[8];
   logic [7:0] wgt_v[8];
   logic [1:0][1:0] hist;
   logic [1:0] prev_ov;
   logic [1:0][7:0] held;
   int acc_pulses[2];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- DUTs and MAC stubs ----------------
   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic signed [7:0] op_a, op_b;
      longint prod, acc, qop, qprod, rnd;
      logic [7:0] dsp_q;

      mac_seq #(.N_IN((g == 0) ? 4 : 1), .CNT_W(10)) u_dut (
         .clk_i(clk),
         .rstn_i(rstn),
         .start_i(start[g]),
         .busy_o(busy[g]),
         .in_valid_i(in_valid[g]),
         .in_ready_o(in_ready[g]),
         .in_image_i(in_image[g]),
         .in_weight_i(in_weight[g]),
         .mac_en_o(mac_en[g]),
         .acc_en_o(acc_en[g]),
         .relu_en_o(relu_en[g]),
         .qdq_en_o(qdq_en[g]),
         .round_en_o(round_en[g]),
         .sat_en_o(sat_en[g]),
         .mac_clear_o(mac_clear[g]),
         .image_data_o(image_data[g]),
         .weight_data_o(weight_data[g]),
         .dsp_output_i(dsp_out[g]),
         .out_valid_o(out_valid[g]),
         .out_ready_i(out_ready[g]),
`ifdef MAC_SEQ_STALL_CNT_EN
         .stall_cnt_o(stall_cnt[g]),
`endif
         .state_o(dbg_state[g]),
         .out_data_o(out_data[g])
      );

      initial begin
         op_a = '0; op_b = '0; prod = 0; acc = 0; qop = 0; qprod = 0; rnd = 0; dsp_q = '0;
      end

      // Pipelined MAC stand-in: misaligned strobes corrupt the result.
      always @(posedge clk) begin
         if (mac_en[g]) begin
            op_a <= image_data[g];
            op_b <= weight_data[g];
         end
         prod <= longint'(op_a) * longint'(op_b);
         if (mac_clear[g]) acc <= 0;
         else if (acc_en[g]) acc <= acc + prod;
         else if (relu_en[g] && acc < 0) acc <= 0;
         if (qdq_en[g]) qop <= acc;
         qprod <= qop * 37;
         if (round_en[g]) rnd <= (qprod + 32768) >>> 16;
         if (sat_en[g]) dsp_q <= (rnd > 127) ? 8'd127 : ((rnd < -128) ? 8'h80 : rnd[7:0]);
      end

      assign dsp_out[g] = dsp_q;
   end

   // ---------------- scoreboard / model ----------------
   task automatic chk(input string name, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   function automatic logic [7:0] model_neuron(input int n);
      longint s;
      s = 0;
      for (int i = 0; i < n; i++) s += longint'($signed(img_v[i])) * longint'($signed(wgt_v[i]));
      if (s < 0) s = 0;
      s = (s * 37 + 32768) >>> 16;
      if (s > 127) s = 127;
      return s[7:0];
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) hist <= '0;
      else for (int g = 0; g < 2; g++) hist[g] <= {hist[g][0], in_valid[g]};
   end

   // Per-cycle compare against the bench's own expectations.
   always @(negedge clk) begin
      logic [8:0] e;
      if (!rstn) begin
         prev_ov = '0;
      end else begin
         for (int g = 0; g < 2; g++) begin
            chk("mac_en", mac_en[g], in_valid[g]);
            chk("acc_en_align", acc_en[g], hist[g][1]);
            chk("enable_excl",
                ($countones({relu_en[g], qdq_en[g], round_en[g], sat_en[g]}) <= 1) &&
                !(acc_en[g] && (relu_en[g] | qdq_en[g] | round_en[g] | sat_en[g])) &&
                !(mac_clear[g] && acc_en[g]), 1);
            if (acc_en[g]) acc_pulses[g]++;
            if (out_valid[g] && !prev_ov[g]) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_out", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", {g[0], out_data[g]}, e);
               end
            end else if (out_valid[g] && prev_ov[g]) begin
               chk("out_hold", out_data[g], held[g]);
            end
            prev_ov[g] = out_valid[g];
            held[g]    = out_data[g];
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic reset_checks();
      for (int g = 0; g < 2; g++) begin
         chk("rst_busy", busy[g], 0);
         chk("rst_out_valid", out_valid[g], 0);
         chk("rst_out_data", out_data[g], 0);
         chk("rst_ready", in_ready[g], 0);
         chk("rst_enables", {acc_en[g], relu_en[g], qdq_en[g], round_en[g], sat_en[g]}, 0);
         chk("rst_clear", mac_clear[g], 1);
`ifdef MAC_SEQ_STALL_CNT_EN
         chk("rst_stall_cnt", stall_cnt[g], 0);
`endif
      end
   endtask

   task automatic send_pair(input int g, input int i);
      in_valid[g]  = 1'b1;
      in_image[g]  = img_v[i];
      in_weight[g] = wgt_v[i];
      @(posedge clk);
      #1;
      in_valid[g] = 1'b0;
   endtask

   task automatic run_neuron(input int g, input int n, input int stall_at, input int stall_len,
                             input int hold, input int lit, input bit pulse_start);
      logic [7:0] e;
      int k;
      int p0;
      e = model_neuron(n);
      chk("model_pin", e, lit);
      exp_q.push_back({g[0], e});
      p0 = acc_pulses[g];
      start[g] = 1'b1;
      @(posedge clk);
      #1;
      start[g] = 1'b0;
      chk("busy_in_load", busy[g], 1);
      for (int i = 0; i < n; i++) begin
         if (i == stall_at) repeat (stall_len) begin
            @(posedge clk);
            #1;
         end
         send_pair(g, i);
      end
      k = 0;
      while (!out_valid[g] && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("latency", k, 8);
      chk("acc_pulses", acc_pulses[g] - p0, n);
      chk("out_lit", out_data[g], lit);
      for (int h = 0; h < hold; h++) begin
         start[g] = pulse_start;
         @(posedge clk);
         #1;
         start[g] = 1'b0;
         chk("out_valid_held", out_valid[g], 1);
      end
      out_ready[g] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[g] = 1'b0;
      chk("out_valid_drop", out_valid[g], 0);
      chk("idle_after_ack", busy[g], 0);
      @(posedge clk);
      #1;
      chk("stay_idle", busy[g], 0);
      chk("idle_clear", mac_clear[g], 1);
   endtask

   task automatic fill(input logic [7:0] a0, a1, a2, a3, input logic [7:0] b0, b1, b2, b3);
      img_v[0] = a0; img_v[1] = a1; img_v[2] = a2; img_v[3] = a3;
      wgt_v[0] = b0; wgt_v[1] = b1; wgt_v[2] = b2; wgt_v[3] = b3;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      n_chk = 0; n_pass = 0;
      acc_pulses[0] = 0; acc_pulses[1] = 0;
      prev_ov = '0; held = '0;
      start = '0; in_valid = '0; out_ready = '0;
      in_image = '0; in_weight = '0;
      for (int i = 0; i < 8; i++) begin img_v[i] = '0; wgt_v[i] = '0; end
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_checks();
      rstn = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // All-127 data: 4*16129*37 / 2^16 rounds to 36.
      fill(8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127);
      run_neuron(0, 4, -1, 0, 0, 36, 1'b0);
`ifdef MAC_SEQ_STALL_CNT_EN
      chk("stall_cnt_zero", stall_cnt[0], 0);
`endif

      // Negative sum clamped by ReLU.
      fill(8'd50, 8'd50, 8'd50, 8'd50, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      run_neuron(0, 4, -1, 0, 0, 0, 1'b0);

      // Three-cycle stall between pairs 2 and 3.
      fill(8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127);
      run_neuron(0, 4, 2, 3, 0, 36, 1'b0);
`ifdef MAC_SEQ_STALL_CNT_EN
      chk("stall_cnt_three", stall_cnt[0], 3);
`endif

      // Output back-pressure for 5 cycles with start pulsed during OUT.
      run_neuron(0, 4, -1, 0, 5, 36, 1'b1);

      // Mixed signs: 12700+16384+16129+11430 = 56643 -> 32.
      fill(8'd100, 8'h80, 8'd127, 8'd90, 8'd127, 8'h80, 8'd127, 8'd127);
      run_neuron(0, 4, -1, 0, 0, 32, 1'b0);

      // Reset in the middle of LOAD after two pairs.
      fill(8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127);
      start[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      send_pair(0, 0);
      send_pair(0, 1);
      rstn = 1'b0;
      #1;
      chk("midrst_busy", busy[0], 0);
      chk("midrst_ready", in_ready[0], 0);
      chk("midrst_out_valid", out_valid[0], 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      chk("midrst_no_output", out_valid[0], 0);
      run_neuron(0, 4, -1, 0, 0, 36, 1'b0);

      // N_IN = 1 instance: 16129*37 / 2^16 rounds to 9.
      img_v[0] = 8'd127;
      wgt_v[0] = 8'd127;
      run_neuron(1, 1, -1, 0, 2, 9, 1'b0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Control sequencer directly upstream of the 8-bit MAC/requantise datapath in the MNIST streamline.
- Accepts a stream of signed (image, weight) byte pairs over a valid/ready handshake and drives the MAC's operand and enable pins with the correct pipeline alignment.
- After the N_IN-th pair, runs the post-processing sequence (drain, ReLU, QDQ multiply, round, saturate) and captures the 8-bit neuron result.
- Presents the result on a valid/ready output port.

Parameters:
N_IN, 784, number of products accumulated per neuron; legal range 1..2**CNT_W.
CNT_W, 10, width of the input pair counter.

Ports:
clk_i  input  1  clock
rstn_i  input  1  asynchronous active-low reset
start_i  input  1  begin one neuron; sampled only in IDLE
busy_o  output  1  high in every state except IDLE
in_valid_i  input  1  input pair valid
in_ready_o  output  1  high only in LOAD
in_image_i  input  8  signed image byte
in_weight_i  input  8  signed weight byte
mac_en_o  output  1  to MAC mac_en; equals in_valid_i & in_ready_o
acc_en_o  output  1  to MAC acc_en
relu_en_o  output  1  to MAC relu_en
qdq_en_o  output  1  to MAC qdq_en
round_en_o  output  1  to MAC round_en
sat_en_o  output  1  to MAC sat_en
mac_clear_o  output  1  to MAC mac_clear
image_data_o  output  8  combinational pass-through of in_image_i
weight_data_o  output  8  combinational pass-through of in_weight_i
dsp_output_i  input  8  MAC result
out_valid_o  output  1  result valid
out_ready_i  input  1  result accepted
out_data_o  output  8  registered neuron result

Behaviour:
- Reset (async assert, synchronous deassert at the system level):
  - State IDLE; counter 0; acc-delay pipe 0; out_valid_o 0; out_data_o 0.
  - All enables 0.
  - Reset mid-neuron abandons the neuron; no partial output is produced.
- acc_en_o is mac_en_o delayed by exactly 2 registered stages (operand register, then multiplier). It is never generated any other way. Stalls (in_valid_i low) therefore create gaps in acc_en_o identical to the gaps in mac_en_o.
- FSM:
  - IDLE: mac_clear_o = 1 every cycle. On start_i -> LOAD, counter <= 0.
  - LOAD: in_ready_o = 1.
    - Each handshake increments the counter.
    - Handshake when counter == N_IN-1 -> DRAIN0.
    - in_valid_i low: hold, no counting.
  - DRAIN0, DRAIN1: one cycle each; the last acc_en_o pulse falls in DRAIN1.
  - RELU: relu_en_o = 1 for 1 cycle.
  - QDQ: qdq_en_o = 1 for 1 cycle. The MAC loads the post-ReLU accumulator into its operand.
  - MULW: 1 idle cycle while the MAC multiplier registers the product.
  - ROUND: round_en_o = 1 for 1 cycle.
  - SAT: sat_en_o = 1 for 1 cycle.
  - CAPT: out_data_o <= dsp_output_i; out_valid_o <= 1 -> OUT.
  - OUT: hold out_data_o and out_valid_o until out_ready_i. On handshake, out_valid_o <= 0 -> IDLE.
- Enable exclusivity:
  - At most one of relu/qdq/round/sat enables is high in any cycle.
  - None of them overlaps acc_en_o.
  - mac_clear_o is never high while acc_en_o is high.
- Latency: last input handshake to out_valid_o = 8 cycles (DRAIN0 through CAPT plus the register).
- start_i outside IDLE is ignored.
- N_IN = 1: the first handshake goes directly to DRAIN0.
- Counter never wraps; it is reset on entry to LOAD.

Optional Feature:
- Macro: MAC_SEQ_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o [15:0], counting LOAD cycles with in_valid_i = 0.
  - Saturates at 16'hFFFF.
  - Clears on entry to LOAD; holds its value after leaving LOAD.
  - Async reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- N_IN=4, no stalls, images 127,127,127,127, weights 127×4, MAC COEFF=0x25 -> exactly 4 acc_en_o pulses, each 2 cycles after its mac_en_o; out_data_o = 36; out_valid_o 8 cycles after last handshake.
- N_IN=4, weights all -1, images 50 -> ReLU zeroes the accumulator -> out_data_o = 0.
- N_IN=4, in_valid_i low for 3 cycles between pairs 2 and 3 -> acc_en_o shows the same 3-cycle gap; result 36 (127 data). With MAC_SEQ_STALL_CNT_EN defined, stall_cnt_o = 3.
- out_ready_i held low 5 cycles after out_valid_o -> out_data_o and out_valid_o stable; start_i pulsed during OUT is ignored; IDLE entered one cycle after out_ready_i.
- rstn_i asserted during LOAD after 2 pairs -> immediate IDLE, busy_o 0, no out_valid_o; the next neuron (127 data) gives 36.
- N_IN=1, image 127, weight 127 -> one acc_en_o pulse; sequence completes; every cycle checked for enable exclusivity.
